// File: rtl/div_result_fifo.sv
// Result buffer behind the restoring divider: captures {quotient, remainder} pairs,
// queues up to DEPTH of them for a valid/ready consumer, and throttles/flags the producer.
module div_result_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       div_valid_out,
    input  logic [WIDTH-1:0]           div_quotient,
    input  logic [WIDTH-1:0]           div_remainder,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [WIDTH-1:0]           res_quotient,
    output logic [WIDTH-1:0]           res_remainder,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [2*WIDTH-1:0] entry [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count_r;
    logic               overflow_r;
    logic               full;
    logic               push;
    logic               pop;

    assign full      = (count_r == CW'(DEPTH));
    assign res_valid = (count_r != '0);
    assign pop       = res_valid & res_ready;
    // A simultaneous pop frees the slot, so a full buffer can still accept.
    assign push      = div_valid_out & (~full | pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entry[i] <= '0;
            end
        end else begin
            if (push) begin
                entry[wr_ptr] <= {div_quotient, div_remainder};
                wr_ptr        <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (div_valid_out && full && !pop) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign {res_quotient, res_remainder} = entry[rd_ptr];
    assign count       = count_r;
    assign almost_full = (count_r >= CW'(DEPTH - 1));
    assign overflow    = overflow_r;

endmodule

// File: tb/tb_div_result_fifo.sv
// Directed vector bench for div_result_fifo (WIDTH=32, DEPTH=4): table of
// per-cycle stimulus/expectations plus a streaming push/pop sequence.
module tb_div_result_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             div_valid_out;
    logic [WIDTH-1:0] div_quotient;
    logic [WIDTH-1:0] div_remainder;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_quotient;
    logic [WIDTH-1:0] res_remainder;
    logic [2:0]       count;
    logic             almost_full;
    logic             overflow;

    int checks   = 0;
    int failures = 0;

    div_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .div_valid_out (div_valid_out),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_quotient  (res_quotient),
        .res_remainder (res_remainder),
        .count         (count),
        .almost_full   (almost_full),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          v;
        logic [31:0] q;
        logic [31:0] r;
        bit          rdy;
        bit          ev;
        logic [31:0] eq;
        logic [31:0] er;
        logic [31:0] ecnt;
        bit          eaf;
        bit          eovf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic drive(input bit rst, input bit v, input logic [31:0] q,
                         input logic [31:0] r, input bit rdy);
        reset         = rst;
        div_valid_out = v;
        div_quotient  = q;
        div_remainder = r;
        res_ready     = rdy;
    endtask

    initial begin
        drive(1'b0, 1'b0, '0, '0, 1'b0);

        //               rst v  q   r    rdy  ev q   r    cnt af ovf
        // reset, idle
        vecs.push_back('{1, 0, 0,  0,   0,   0, 0,  0,   0, 0, 0});
        vecs.push_back('{0, 0, 0,  0,   0,   0, 0,  0,   0, 0, 0});
        // single push, hold while stalled, pop
        vecs.push_back('{0, 1, 7,  2,   0,   1, 7,  2,   1, 0, 0});
        vecs.push_back('{0, 0, 0,  0,   0,   1, 7,  2,   1, 0, 0});
        vecs.push_back('{0, 0, 0,  0,   1,   0, 0,  0,   0, 0, 0});
        // five pushes while stalled: fifth dropped, overflow sticks
        vecs.push_back('{0, 1, 1,  10,  0,   1, 1,  10,  1, 0, 0});
        vecs.push_back('{0, 1, 2,  20,  0,   1, 1,  10,  2, 0, 0});
        vecs.push_back('{0, 1, 3,  30,  0,   1, 1,  10,  3, 1, 0});
        vecs.push_back('{0, 1, 4,  40,  0,   1, 1,  10,  4, 1, 0});
        vecs.push_back('{0, 1, 5,  50,  0,   1, 1,  10,  4, 1, 1});
        vecs.push_back('{0, 0, 0,  0,   1,   1, 2,  20,  3, 1, 1});
        vecs.push_back('{0, 0, 0,  0,   1,   1, 3,  30,  2, 0, 1});
        vecs.push_back('{0, 0, 0,  0,   1,   1, 4,  40,  1, 0, 1});
        vecs.push_back('{0, 0, 0,  0,   1,   0, 1,  10,  0, 0, 1});
        // count=3 with overflow set, then reset with a push in the same cycle
        vecs.push_back('{0, 1, 11, 1,   0,   1, 11, 1,   1, 0, 1});
        vecs.push_back('{0, 1, 12, 2,   0,   1, 11, 1,   2, 0, 1});
        vecs.push_back('{0, 1, 13, 3,   0,   1, 11, 1,   3, 1, 1});
        vecs.push_back('{1, 1, 99, 99,  0,   0, 0,  0,   0, 0, 0});
        vecs.push_back('{0, 0, 0,  0,   0,   0, 0,  0,   0, 0, 0});
        // fill, then push+pop while full: no overflow
        vecs.push_back('{0, 1, 1,  101, 0,   1, 1,  101, 1, 0, 0});
        vecs.push_back('{0, 1, 2,  102, 0,   1, 1,  101, 2, 0, 0});
        vecs.push_back('{0, 1, 3,  103, 0,   1, 1,  101, 3, 1, 0});
        vecs.push_back('{0, 1, 4,  104, 0,   1, 1,  101, 4, 1, 0});
        vecs.push_back('{0, 1, 9,  109, 1,   1, 2,  102, 4, 1, 0});
        vecs.push_back('{0, 0, 0,  0,   1,   1, 3,  103, 3, 1, 0});
        vecs.push_back('{0, 0, 0,  0,   1,   1, 4,  104, 2, 0, 0});
        vecs.push_back('{0, 0, 0,  0,   1,   1, 9,  109, 1, 0, 0});
        vecs.push_back('{0, 0, 0,  0,   1,   0, 2,  102, 0, 0, 0});
        // empty + push + ready: no pop in that cycle
        vecs.push_back('{0, 1, 5,  105, 1,   1, 5,  105, 1, 0, 0});
        vecs.push_back('{0, 0, 0,  0,   1,   0, 3,  103, 0, 0, 0});

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].v, vecs[i].q, vecs[i].r, vecs[i].rdy);
            @(posedge clk);
            #1;
            check($sformatf("v%0d.res_valid", i),     32'(res_valid),   32'(vecs[i].ev));
            check($sformatf("v%0d.res_quotient", i),  res_quotient,     vecs[i].eq);
            check($sformatf("v%0d.res_remainder", i), res_remainder,    vecs[i].er);
            check($sformatf("v%0d.count", i),         32'(count),       vecs[i].ecnt);
            check($sformatf("v%0d.almost_full", i),   32'(almost_full), 32'(vecs[i].eaf));
            check($sformatf("v%0d.overflow", i),      32'(overflow),    32'(vecs[i].eovf));
        end

        // Streaming: push and pop every cycle for 12 results (three pointer wraps).
        for (int k = 0; k < 12; k++) begin
            drive(1'b0, 1'b1, 32'(200 + k), 32'(k), 1'b1);
            @(posedge clk);
            #1;
            check($sformatf("s%0d.res_valid", k),     32'(res_valid), 32'd1);
            check($sformatf("s%0d.res_quotient", k),  res_quotient,   32'(200 + k));
            check($sformatf("s%0d.res_remainder", k), res_remainder,  32'(k));
            check($sformatf("s%0d.count", k),         32'(count),     32'd1);
        end
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        @(posedge clk);
        #1;
        check("stream_drain.count",     32'(count),     32'd0);
        check("stream_drain.res_valid", 32'(res_valid), 32'd0);
        check("stream_drain.overflow",  32'(overflow),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
